// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NREQ byte sources share one UART transmitter.
// An owner keeps the transmitter for a whole packet unless it idles past HOLD_TIMEOUT.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int DBIT         = 8,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DBIT-1:0]     req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_start,
  output logic [DBIT-1:0]          d_tx,
  input  logic                     tx_done,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

  state_t          state, state_next;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   rr_winner;
  logic [GW-1:0]   cand;
  logic            rr_found;
  logic [GW-1:0]   sel;
  logic            accept;
  logic            hold_to;
  logic            last_q;
  logic [CW-1:0]   hold_cnt;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rr_found  = 1'b0;
    rr_winner = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = GW'((int'(rr_ptr) + i) % NREQ);
      if (!rr_found && req_valid[cand]) begin
        rr_found  = 1'b1;
        rr_winner = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = 1'b0;
    sel        = grant_id;
    hold_to    = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: if (rr_found) begin
          accept     = 1'b1;
          sel        = rr_winner;
          state_next = START;
        end
        START: state_next = WAIT;
        WAIT: if (tx_done) state_next = last_q ? IDLE : HOLD;
        HOLD: begin
          // Only the current owner is served; everyone else waits for IDLE.
          if (req_valid[grant_id]) begin
            accept     = 1'b1;
            state_next = START;
          end else if (hold_cnt == CW'(HOLD_TIMEOUT)) begin
            hold_to    = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
    if (accept) req_ready[sel] = 1'b1;
  end

  assign tx_start    = (state == START);
  assign busy        = (state != IDLE);
  assign timeout_err = hold_to;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_tx     <= '0;
      last_q   <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= GW'(NREQ - 1);
      hold_cnt <= '0;
    end else begin
      if (accept) begin
        d_tx     <= req_data[int'(sel)*DBIT +: DBIT];
        last_q   <= req_last[sel];
        grant_id <= sel;
        hold_cnt <= '0;
      end
      if (state == WAIT && tx_done) begin
        hold_cnt <= '0;
        if (last_q) rr_ptr <= grant_id;
      end
      // The counter stops at HOLD_TIMEOUT because that cycle leaves HOLD.
      if (state == HOLD && !accept) begin
        if (hold_to) rr_ptr   <= grant_id;
        else         hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round robin, packet hold, hold timeout,
// ignored tx_done and mid-packet reset, with a per-cycle ready/start monitor.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DBIT = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_start;
  logic [DBIT-1:0]      d_tx;
  logic                 tx_done;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 timeout_err;

  int   checks = 0;
  int   errors = 0;
  int   start_count = 0;
  int   tout_count = 0;
  logic prev_start = 1'b0;

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .HOLD_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start), .d_tx(d_tx),
    .tx_done(tx_done), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Every cycle: ready is one-hot-or-zero and tx_start never lasts two cycles.
  always @(negedge clk) begin
    #3;
    if (!reset) begin
      checks++;
      if (!$onehot0(req_ready)) begin
        errors++;
        $display("FAIL ready_onehot: req_ready=%b, required one-hot or zero", req_ready);
      end
      checks++;
      if (tx_start && prev_start) begin
        errors++;
        $display("FAIL start_single: tx_start=1 on two consecutive cycles at %0t", $time);
      end
      if (tx_start) start_count++;
      if (timeout_err) tout_count++;
    end
    prev_start = tx_start;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, required to finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_byte(input int idx, input logic [DBIT-1:0] b);
    req_data[idx*DBIT +: DBIT] = b;
  endtask

  // From START: two WAIT cycles, then a one-cycle tx_done; reports d_tx stability.
  task automatic finish_frame(output logic stable);
    logic [DBIT-1:0] first;
    first  = d_tx;
    stable = 1'b1;
    tick();
    if (d_tx !== first) stable = 1'b0;
    tick();
    if (d_tx !== first) stable = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, tx_start, timeout_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/tx_start/timeout_err=%b, required 000", {busy, tx_start, timeout_err});
    end
    checks++;
    if (grant_id !== 2'd0 || d_tx !== 8'h00) begin
      errors++;
      $display("FAIL reset_regs: grant_id=%0d d_tx=%h, required 0 and 00", grant_id, d_tx);
    end
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b during reset, required 0000", req_ready);
    end
    req_valid = '0;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b after release, required 0", busy);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] bytes [4];
    logic       stable;
    int         base;
    bytes = '{8'h3C, 8'hA5, 8'h5A, 8'hC3};
    base  = start_count;
    for (int i = 0; i < NREQ; i++) set_byte(i, bytes[i]);
    req_last  = 4'hF;
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < NREQ; k++) begin
      checks++;
      if (req_ready !== 4'(1 << k)) begin
        errors++;
        $display("FAIL rr_ready: turn %0d req_ready=%b, required %b", k, req_ready, 4'(1 << k));
      end
      tick();
      req_valid[k] = 1'b0;
      #1;
      checks++;
      if ({tx_start, grant_id, d_tx} !== {1'b1, 2'(k), bytes[k]}) begin
        errors++;
        $display("FAIL rr_frame: turn %0d start=%b grant=%0d d_tx=%h, required 1 %0d %h",
                 k, tx_start, grant_id, d_tx, k, bytes[k]);
      end
      finish_frame(stable);
      checks++;
      if (stable !== 1'b1) begin
        errors++;
        $display("FAIL rr_stable: turn %0d d_tx changed during frame, required stable", k);
      end
    end
    checks++;
    if (busy !== 1'b0 || start_count - base !== 4) begin
      errors++;
      $display("FAIL rr_end: busy=%b starts=%0d, required 0 and 4", busy, start_count - base);
    end
  endtask

  task automatic test_hold_packet();
    logic [7:0] pkt [3];
    logic       stable;
    pkt = '{8'h41, 8'h42, 8'h43};
    // Requester 1 alone first, so the pointer sits at 1 and requester 2 is searched first.
    set_byte(1, 8'h99);
    req_last  = 4'b0010;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    finish_frame(stable);
    set_byte(2, pkt[0]);
    req_valid = 4'b0110;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL hp_first: req_ready=%b, required 0100", req_ready);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      if (j < 2) begin
        set_byte(2, pkt[j+1]);
        req_last[2] = (j == 1);
      end else begin
        req_valid[2] = 1'b0;
      end
      #1;
      checks++;
      if ({tx_start, grant_id, d_tx} !== {1'b1, 2'd2, pkt[j]}) begin
        errors++;
        $display("FAIL hp_frame: byte %0d start=%b grant=%0d d_tx=%h, required 1 2 %h",
                 j, tx_start, grant_id, d_tx, pkt[j]);
      end
      finish_frame(stable);
      if (j < 2) begin
        checks++;
        if (req_ready !== 4'b0100 || busy !== 1'b1) begin
          errors++;
          $display("FAIL hp_hold: byte %0d req_ready=%b busy=%b, required 0100 1", j, req_ready, busy);
        end
      end
    end
    checks++;
    if (req_ready !== 4'b0010 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hp_next: req_ready=%b busy=%b, required 0010 0", req_ready, busy);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if ({tx_start, grant_id, d_tx} !== {1'b1, 2'd1, 8'h99}) begin
      errors++;
      $display("FAIL hp_other: start=%b grant=%0d d_tx=%h, required 1 1 99", tx_start, grant_id, d_tx);
    end
    finish_frame(stable);
  endtask

  task automatic test_tx_done_ignored();
    logic stable;
    int   base;
    base    = start_count;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || start_count !== base) begin
      errors++;
      $display("FAIL done_idle: busy=%b tx_start=%b starts=%0d, required 0 0 0", busy, tx_start, start_count - base);
    end
    set_byte(0, 8'h11);
    req_last  = 4'b0000;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    finish_frame(stable);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || tx_start !== 1'b0 || start_count - base !== 1) begin
      errors++;
      $display("FAIL done_hold: busy=%b tx_start=%b starts=%0d, required 1 0 1", busy, tx_start, start_count - base);
    end
    set_byte(0, 8'h22);
    req_last  = 4'b0001;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL done_resume: req_ready=%b, required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    tx_done   = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL done_in_start: busy=%b after tx_done during START, required 1", busy);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (busy !== 1'b0 || d_tx !== 8'h22) begin
      errors++;
      $display("FAIL done_finish: busy=%b d_tx=%h, required 0 22", busy, d_tx);
    end
  endtask

  task automatic test_timeout();
    logic stable;
    int   base;
    int   n;
    base = tout_count;
    set_byte(3, 8'h55);
    req_last  = 4'b0000;
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL to_ready: req_ready=%b, required 1000", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (grant_id !== 2'd3 || d_tx !== 8'h55) begin
      errors++;
      $display("FAIL to_frame: grant=%0d d_tx=%h, required 3 55", grant_id, d_tx);
    end
    finish_frame(stable);
    n = 0;
    while (!timeout_err && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 255) begin
      errors++;
      $display("FAIL to_latency: idle HOLD cycles before timeout=%0d, required 255", n);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b0 || tout_count - base !== 1) begin
      errors++;
      $display("FAIL to_after: busy=%b timeout_err=%b pulses=%0d, required 0 0 1",
               busy, timeout_err, tout_count - base);
    end
    req_last  = 4'hF;
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL to_next: req_ready=%b, required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    finish_frame(stable);
  endtask

  task automatic test_reset_in_wait();
    logic stable;
    int   base;
    base = tout_count;
    set_byte(1, 8'h77);
    set_byte(0, 8'h66);
    req_last  = 4'b0010;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rw_ready: req_ready=%b, required 0010", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL rw_wait: busy=%b grant=%0d, required 1 1", busy, grant_id);
    end
    req_valid = 4'b0011;
    req_last  = 4'b0011;
    reset     = 1'b1;
    #1;
    checks++;
    if ({busy, tx_start, timeout_err, req_ready} !== 7'b0) begin
      errors++;
      $display("FAIL rw_async: busy=%b tx_start=%b timeout_err=%b req_ready=%b, required all 0",
               busy, tx_start, timeout_err, req_ready);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rw_priority: req_ready=%b after reset, required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if ({tx_start, grant_id, d_tx} !== {1'b1, 2'd0, 8'h66}) begin
      errors++;
      $display("FAIL rw_grant: start=%b grant=%0d d_tx=%h, required 1 0 66", tx_start, grant_id, d_tx);
    end
    finish_frame(stable);
    checks++;
    if (busy !== 1'b0 || tout_count !== base) begin
      errors++;
      $display("FAIL rw_end: busy=%b timeout pulses=%0d, required 0 0", busy, tout_count - base);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold_packet();
    test_tx_done_ignored();
    test_timeout();
    test_reset_in_wait();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
